// File: rtl/dual_ram_arbiter.sv
// Round-robin arbiter sharing one two-port synchronous RAM among N_REQ requesters.
// Define ARB_STATS_EN to add saturating grant and write-conflict counters.
module dual_ram_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_N = 32,
    parameter int SIZE   = 128,
    parameter int AW     = $clog2(SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*AW-1:0]       req_addr,
    input  logic [N_REQ*DATA_N-1:0]   req_wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rvalid,
    output logic [N_REQ*DATA_N-1:0]   rdata,
    output logic                      we0,
    output logic                      we1,
    output logic [AW-1:0]             addr0,
    output logic [AW-1:0]             addr1,
    output logic [DATA_N-1:0]         w0_data,
    output logic [DATA_N-1:0]         w1_data,
    input  logic [DATA_N-1:0]         r0_data,
    input  logic [DATA_N-1:0]         r1_data
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]               stat_grants,
    output logic [31:0]               stat_conflicts
`endif
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef struct packed {
        logic          v;
        logic [PW-1:0] idx;
    } resp_t;

    logic [PW-1:0] ptr;
    resp_t         resp0, resp1;
    logic          a_ok, b_ok;
    logic [PW-1:0] a_idx, b_idx;
`ifdef ARB_STATS_EN
    logic          skip;
`endif

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // Scan from ptr; port 1 never takes a write to the same address as a port-0 write.
    always_comb begin
        int j;
        j     = 0;
        a_ok  = 1'b0;
        b_ok  = 1'b0;
        a_idx = '0;
        b_idx = '0;
`ifdef ARB_STATS_EN
        skip  = 1'b0;
`endif
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[j] && !rst) begin
                if (!a_ok) begin
                    a_ok  = 1'b1;
                    a_idx = PW'(j);
                end else if (!b_ok) begin
                    if (req_we[j] && req_we[a_idx] &&
                        req_addr[j*AW +: AW] == req_addr[a_idx*AW +: AW]) begin
`ifdef ARB_STATS_EN
                        skip = 1'b1;
`endif
                    end else begin
                        b_ok  = 1'b1;
                        b_idx = PW'(j);
                    end
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (a_ok) gnt[a_idx] = 1'b1;
        if (b_ok) gnt[b_idx] = 1'b1;
        we0     = a_ok & req_we[a_idx];
        addr0   = a_ok ? req_addr[a_idx*AW +: AW] : '0;
        w0_data = a_ok ? req_wdata[a_idx*DATA_N +: DATA_N] : '0;
        we1     = b_ok & req_we[b_idx];
        addr1   = b_ok ? req_addr[b_idx*AW +: AW] : '0;
        w1_data = b_ok ? req_wdata[b_idx*DATA_N +: DATA_N] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            resp0 <= '0;
            resp1 <= '0;
        end else begin
            resp0 <= '{v: a_ok && !req_we[a_idx], idx: a_idx};
            resp1 <= '{v: b_ok && !req_we[b_idx], idx: b_idx};
            if (b_ok)      ptr <= nxt(b_idx);
            else if (a_ok) ptr <= nxt(a_idx);
        end
    end

    // RAM data is registered, so it lines up with the response registers.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (resp0.v && resp0.idx == PW'(i)) begin
                rvalid[i]                    = 1'b1;
                rdata[i*DATA_N +: DATA_N]    = r0_data;
            end else if (resp1.v && resp1.idx == PW'(i)) begin
                rvalid[i]                    = 1'b1;
                rdata[i*DATA_N +: DATA_N]    = r1_data;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [32:0] gsum;
    always_comb gsum = {1'b0, stat_grants} + 33'(a_ok) + 33'(b_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants    <= '0;
            stat_conflicts <= '0;
        end else begin
            stat_grants <= gsum[32] ? 32'hFFFF_FFFF : gsum[31:0];
            if (skip && stat_conflicts != 32'hFFFF_FFFF)
                stat_conflicts <= stat_conflicts + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dual_ram_arbiter.sv
// Directed bench for dual_ram_arbiter with a behavioural read-before-write RAM.
module tb_dual_ram_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_we, gnt, rvalid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata, rdata;
    logic            we0, we1;
    logic [AW-1:0]   addr0, addr1;
    logic [DW-1:0]   w0_data, w1_data, r0_data, r1_data;
`ifdef ARB_STATS_EN
    logic [31:0]     stat_grants, stat_conflicts;
`endif

    logic [DW-1:0]   mem [0:127];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dual_ram_arbiter #(.N_REQ(N), .DATA_N(DW), .SIZE(128)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .w0_data(w0_data), .w1_data(w1_data), .r0_data(r0_data), .r1_data(r1_data)
`ifdef ARB_STATS_EN
        , .stat_grants(stat_grants), .stat_conflicts(stat_conflicts)
`endif
    );

    // Registered read, old data returned on a same-address write.
    always @(posedge clk) begin
        r0_data <= mem[addr0];
        r1_data <= mem[addr1];
        if (we0) mem[addr0] <= w0_data;
        if (we1) mem[addr1] <= w1_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rq(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000 + i;
        mem[5] = 32'hA5;
        mem[7] = 32'h1234;
        rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;

        // Reset holds everything quiet even with a request pending
        req = 4'b0001; set_rq(0, 1'b0, 7'd5, '0);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_we0", we0, 0);
        chk("rst_addr0", addr0, 0);
        tick();
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        tick();

        // Single read after reset
        rst = 1'b0;
        #1;
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_addr0", addr0, 5);
        chk("t1_we1", we1, 0);
        chk("t1_addr1", addr1, 0);
        tick();
        chk("t1_rvalid", rvalid, 4'b0001);
        chk("t1_rdata0", rdata[0*DW +: DW], 32'hA5);

        // Reset mid-operation (ptr was 1)
        req = 4'b0100; set_rq(2, 1'b0, 7'd2, '0); rst = 1'b1;
        #1;
        chk("rm_gnt", gnt, 0);
        tick();
        chk("rm_rvalid", rvalid, 0);
        chk("rm_rdata", rdata, 0);
        rst = 1'b0;
        req = 4'b0101; set_rq(0, 1'b0, 7'd10, '0); set_rq(2, 1'b0, 7'd11, '0);
        #1;
        chk("rm2_gnt", gnt, 4'b0101);
        chk("rm2_addr0", addr0, 10);
        chk("rm2_addr1", addr1, 11);
        tick();
        chk("rm2_rvalid", rvalid, 4'b0101);
        chk("rm2_rdata0", rdata[0*DW +: DW], 32'h100A);
        chk("rm2_rdata2", rdata[2*DW +: DW], 32'h100B);

        // Wrap: ptr=3
        req = 4'b1001; set_rq(3, 1'b0, 7'd20, '0); set_rq(0, 1'b0, 7'd21, '0);
        #1;
        chk("wr_gnt", gnt, 4'b1001);
        chk("wr_addr0", addr0, 20);
        chk("wr_addr1", addr1, 21);
        tick();
        chk("wr_rvalid", rvalid, 4'b1001);
        chk("wr_rdata3", rdata[3*DW +: DW], 32'h1014);
        chk("wr_rdata0", rdata[0*DW +: DW], 32'h1015);
        // ptr now 1: only requester 0 active lands on port 0, port 1 idle
        req = 4'b0001; set_rq(0, 1'b0, 7'd22, '0);
        #1;
        chk("wr2_gnt", gnt, 4'b0001);
        chk("wr2_we1", we1, 0);
        chk("wr2_addr1", addr1, 0);
        tick();

        // Four persistent reads from ptr=0
        req = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) set_rq(i, 1'b0, AW'(30 + i), '0);
        #1;
        chk("p0_gnt", gnt, 4'b0011);
        chk("p0_addr0", addr0, 30);
        chk("p0_addr1", addr1, 31);
        tick();
        chk("p0_rvalid", rvalid, 4'b0011);
        chk("p0_rdata0", rdata[0*DW +: DW], 32'h101E);
        chk("p0_rdata1", rdata[1*DW +: DW], 32'h101F);
        #1;
        chk("p1_gnt", gnt, 4'b1100);
        tick();
        chk("p1_rvalid", rvalid, 4'b1100);
        chk("p1_rdata2", rdata[2*DW +: DW], 32'h1020);
        chk("p1_rdata3", rdata[3*DW +: DW], 32'h1021);
        #1;
        chk("p2_gnt", gnt, 4'b0011);
        tick();
        chk("p2_rvalid", rvalid, 4'b0011);
        chk("p2_rdata1", rdata[1*DW +: DW], 32'h101F);

        // Write-write conflict on address 9
        req = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0111;
        set_rq(0, 1'b1, 7'd9, 32'h11); set_rq(1, 1'b1, 7'd9, 32'h22); set_rq(2, 1'b0, 7'd3, '0);
        #1;
        chk("ww_gnt", gnt, 4'b0101);
        chk("ww_we0", we0, 1);
        chk("ww_w0", w0_data, 32'h11);
        chk("ww_we1", we1, 0);
        chk("ww_addr1", addr1, 3);
        tick();
        chk("ww_rvalid", rvalid, 4'b0100);
        chk("ww_rdata2", rdata[2*DW +: DW], 32'h1003);
        req = 4'b0010;
        #1;
        chk("ww2_gnt", gnt, 4'b0010);
        chk("ww2_w0", w0_data, 32'h22);
        chk("ww2_we1", we1, 0);
        tick();
        chk("ww2_rvalid", rvalid, 0);
        chk("ww_mem9", mem[9], 32'h22);
`ifdef ARB_STATS_EN
        chk("st_conflicts", stat_conflicts, 1);
        chk("st_grants", stat_grants, 3);
`endif

        // Same-address read+write returns old data (ptr=2)
        req = 4'b0011;
        set_rq(0, 1'b1, 7'd7, 32'hBEEF); set_rq(1, 1'b0, 7'd7, '0);
        #1;
        chk("rw_gnt", gnt, 4'b0011);
        chk("rw_we0", we0, 1);
        chk("rw_addr1", addr1, 7);
        tick();
        chk("rw_rvalid", rvalid, 4'b0010);
        chk("rw_rdata1", rdata[1*DW +: DW], 32'h1234);
        chk("rw_rdata0_zero", rdata[0*DW +: DW], 0);
        req = 4'b0010;
        #1;
        chk("rw2_gnt", gnt, 4'b0010);
        tick();
        chk("rw2_rvalid", rvalid, 4'b0010);
        chk("rw2_rdata1", rdata[1*DW +: DW], 32'hBEEF);
        req = '0;
        tick();
        chk("idle_rvalid", rvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
